wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_master_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_master_arbiter: two-master Wishbone arbiter, round-robin with bus lock |
// | Optional stalled-slave timeout enabled by WB_ARB_TIMEOUT_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [13:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel,
  output logic        m0_ack,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [13:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel,
  output logic        m1_ack,
  output logic [31:0] m_dat_i,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [13:0] s_adr,
  output logic [31:0] s_dat_mosi,
  output logic [3:0]  s_sel,
  input  logic        s_ack,
  input  logic [31:0] s_dat_miso,
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;   // 1: m1 was granted last
  logic        owned;
  logic        sel_cyc, sel_stb, sel_we;
  logic [3:0]  sel_sel;
  logic        fire;

  // last_q tracks the current owner while owning, so one mux serves both cases
  assign owned   = (state_q != IDLE);
  assign sel_cyc = last_q ? m1_cyc : m0_cyc;
  assign sel_stb = last_q ? m1_stb : m0_stb;
  assign sel_we  = last_q ? m1_we  : m0_we;
  assign sel_sel = last_q ? m1_sel : m0_sel;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;

  assign fire = owned & sel_stb & ~s_ack & (cnt_q == TIMEOUT_CYCLES[7:0]);

  always_comb begin
    cnt_d = 8'd0;
    if (owned && state_d == state_q && sel_stb && !s_ack && !fire)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | fire;
    end
  end

  assign timeout = timeout_q;
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES[7:0];
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = OWN0;
          grant_d = 2'b01;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = OWN1;
          grant_d = 2'b10;
          last_d  = 1'b1;
        end
      end
      OWN0: if (!m0_cyc) begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      OWN1: if (!m1_cyc) begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant      = grant_q;
  assign s_cyc      = owned & sel_cyc;
  assign s_stb      = owned & sel_stb & ~fire;
  assign s_we       = owned & sel_we;
  assign s_sel      = owned ? sel_sel : 4'd0;
  assign s_adr      = last_q ? m1_adr   : m0_adr;
  assign s_dat_mosi = last_q ? m1_dat_o : m0_dat_o;
  assign m0_ack     = (state_q == OWN0) & ((s_ack & s_stb) | fire);
  assign m1_ack     = (state_q == OWN1) & ((s_ack & s_stb) | fire);
  assign m_dat_i    = fire ? 32'hFFFF_FFFF : s_dat_miso;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// tb_wb_master_arbiter: directed self-checking bench for wb_master_arbiter.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [13:0] m0_adr = '0;
  logic [31:0] m0_dat_o = '0;
  logic [3:0]  m0_sel = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [13:0] m1_adr = '0;
  logic [31:0] m1_dat_o = '0;
  logic [3:0]  m1_sel = '0;
  logic        s_ack = 0;
  logic [31:0] s_dat_miso = '0;
  logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, timeout;
  logic [31:0] m_dat_i, s_dat_mosi;
  logic [13:0] s_adr;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  int vectors = 0;
  int errors  = 0;

  wb_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_ack(m1_ack),
    .m_dat_i(m_dat_i), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_mosi(s_dat_mosi), .s_sel(s_sel),
    .s_ack(s_ack), .s_dat_miso(s_dat_miso), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Read by m0 with a two-cycle slave wait
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 14'h0010; m0_sel = 4'hF;
    #1;
    chk("rd_nocomb_grant", 32'(grant), 32'h0);
    chk("rd_nocomb_scyc", 32'(s_cyc), 32'h0);
    tick();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_sstb", 32'(s_stb), 32'h1);
    chk("rd_sadr", 32'(s_adr), 32'h10);
    chk("rd_noack", 32'(m0_ack), 32'h0);
    tick();
    tick();
    s_ack = 1; s_dat_miso = 32'h1234_5678;
    #1;
    chk("rd_ack", 32'(m0_ack), 32'h1);
    chk("rd_data", m_dat_i, 32'h1234_5678);
    chk("rd_m1ack", 32'(m1_ack), 32'h0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk("rd_ackpulse", 32'(m0_ack), 32'h0);
    tick();
    chk("rd_idle", 32'(grant), 32'h0);
    chk("rd_idle_scyc", 32'(s_cyc), 32'h0);

    // Tie after reset: m0 first, one idle cycle, then m1, then m0 again
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("tie_own0", 32'(grant), 32'h1);
    m0_cyc = 0;
    tick();
    chk("tie_idle", 32'(grant), 32'h0);
    tick();
    chk("tie_own1", 32'(grant), 32'h2);
    m1_cyc = 0; m0_cyc = 1;
    tick();
    chk("tie_idle2", 32'(grant), 32'h0);
    m1_cyc = 1;
    tick();
    chk("tie_own0_again", 32'(grant), 32'h1);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    chk("tie_end", 32'(grant), 32'h0);

    // m1 locks the bus across three writes while m0 keeps requesting
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 14'h3FFF;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3;
    tick();
    chk("lock_own0", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("lock_own1", 32'(grant), 32'h2);
    for (int i = 1; i <= 3; i++) begin
      m1_adr = 14'(i); m1_dat_o = 32'hA000_0000 + 32'(i);
      #1;
      chk("lock_sadr", 32'(s_adr), 32'(i));
      chk("lock_sdat", s_dat_mosi, 32'hA000_0000 + 32'(i));
      chk("lock_swe", 32'(s_we), 32'h1);
      chk("lock_ssel", 32'(s_sel), 32'h3);
      s_ack = 1;
      #1;
      chk("lock_m1ack", 32'(m1_ack), 32'h1);
      chk("lock_m0ack", 32'(m0_ack), 32'h0);
      tick();
      s_ack = 0;
      chk("lock_grant", 32'(grant), 32'h2);
    end
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    chk("lock_idle", 32'(grant), 32'h0);
    tick();
    chk("lock_m0_after", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("lock_end", 32'(grant), 32'h0);

    // Asynchronous reset in the middle of an m1 strobe
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("arst_own1", 32'(grant), 32'h2);
    chk("arst_scyc_pre", 32'(s_cyc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_scyc", 32'(s_cyc), 32'h0);
    chk("arst_sstb", 32'(s_stb), 32'h0);
    m1_cyc = 0; m1_stb = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", 32'(grant), 32'h0);

    // Stalled slave: m0 strobes and the slave never acks
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 14'h0020;
    tick();
    chk("to_grant", 32'(grant), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("to_wait_noack", 32'(m0_ack), 32'h0);
    end
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    chk("to_ack", 32'(m0_ack), 32'h1);
    chk("to_data", m_dat_i, 32'hFFFF_FFFF);
    chk("to_sstb_forced", 32'(s_stb), 32'h0);
    chk("to_m1ack", 32'(m1_ack), 32'h0);
    tick();
    chk("to_ackpulse", 32'(m0_ack), 32'h0);
    chk("to_flag", 32'(timeout), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    tick();
    chk("to_sticky", 32'(timeout), 32'h1);
    chk("to_idle", 32'(grant), 32'h0);
`else
    chk("to_noack", 32'(m0_ack), 32'h0);
    chk("to_sstb_held", 32'(s_stb), 32'h1);
    chk("to_flag_off", 32'(timeout), 32'h0);
    tick();
    chk("to_still_owned", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("to_idle", 32'(grant), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired before end of sequence");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
